// File: rtl/mem_stage.sv
// Memory stage of the five-stage ARM pipeline: EXE/MEM register, fixed-latency
// word-addressed data memory access, and the MEM/WB register.
module mem_stage #(
  parameter int MEM_WORDS   = 64,
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_mem_w_en,
  input  logic [31:0] exe_alu_res,
  input  logic [31:0] exe_val_rm,
  input  logic [3:0]  exe_dest,
  output logic        stall,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [3:0]  dest,
  output logic [31:0] alu_res,
  output logic [31:0] mem_data,
  output logic        mem_err,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // EXE/MEM register
  logic        r_wb_en_q, r_r_en_q, r_w_en_q;
  logic [31:0] r_alu_q, r_rm_q;
  logic [3:0]  r_dest_q;

  logic [31:0] mem_q [MEM_WORDS];

  logic             mem_op, in_range, mem_we;
  logic [31:0]      offset, word_idx, rd_word;
  logic [IDX_W-1:0] idx;

  // Flow control: stall is the only handshake. exe_* is captured on every
  // rising edge where stall is low; while stall is high upstream holds exe_*.
  assign mem_op    = r_r_en_q | r_w_en_q;
  assign stall     = (state_q == S_WAIT);
  assign state_dbg = state_q;

  // Unsigned wrap on the subtraction is caught by the lower-bound compare.
  assign offset   = r_alu_q - 32'(ADDR_BASE);
  assign word_idx = offset >> 2;
  assign in_range = (r_alu_q >= 32'(ADDR_BASE)) && (word_idx < 32'(MEM_WORDS));
  assign idx      = word_idx[IDX_W-1:0];
  assign rd_word  = mem_q[idx];
  assign mem_we   = ~rst & ~stall & r_w_en_q & in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == WAIT_V) state_d = S_ACCESS;
    end else begin
      cnt_d = '0;
      if (exe_mem_r_en | exe_mem_w_en) state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      else                             state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_wb_en_q <= 1'b0;
      r_r_en_q  <= 1'b0;
      r_w_en_q  <= 1'b0;
      r_alu_q   <= '0;
      r_rm_q    <= '0;
      r_dest_q  <= '0;
      wb_en     <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_err   <= 1'b0;
      alu_res   <= '0;
      mem_data  <= '0;
      dest      <= '0;
    end else if (stall) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_wb_en_q <= exe_wb_en;
      r_r_en_q  <= exe_mem_r_en;
      r_w_en_q  <= exe_mem_w_en;
      r_alu_q   <= exe_alu_res;
      r_rm_q    <= exe_val_rm;
      r_dest_q  <= exe_dest;
      wb_en     <= r_wb_en_q;
      mem_r_en  <= r_r_en_q;
      alu_res   <= r_alu_q;
      dest      <= r_dest_q;
      mem_data  <= (r_r_en_q && in_range) ? rd_word : '0;
      mem_err   <= mem_op & ~in_range;
    end
  end

  // Array is not reset; a simultaneous read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= r_rm_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (WAIT_CYCLES = 2 and 0) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_stage;

  localparam int MW = 64;
  localparam int AB = 1024;

  typedef struct packed {
    logic        wb;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  ds;
  } op_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        exe_wb_en [2];
  logic        exe_r     [2];
  logic        exe_w     [2];
  logic [31:0] exe_alu   [2];
  logic [31:0] exe_rm    [2];
  logic [3:0]  exe_dst   [2];
  logic        stall     [2];
  logic        wb_en     [2];
  logic        mem_r_en  [2];
  logic        mem_err   [2];
  logic [31:0] alu_res   [2];
  logic [31:0] mem_data  [2];
  logic [3:0]  dest      [2];
  logic [1:0]  state_dbg [2];

  mem_stage #(.MEM_WORDS(MW), .ADDR_BASE(AB), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst[0]), .exe_wb_en(exe_wb_en[0]), .exe_mem_r_en(exe_r[0]),
    .exe_mem_w_en(exe_w[0]), .exe_alu_res(exe_alu[0]), .exe_val_rm(exe_rm[0]),
    .exe_dest(exe_dst[0]), .stall(stall[0]), .wb_en(wb_en[0]), .mem_r_en(mem_r_en[0]),
    .dest(dest[0]), .alu_res(alu_res[0]), .mem_data(mem_data[0]), .mem_err(mem_err[0]),
    .state_dbg(state_dbg[0])
  );

  mem_stage #(.MEM_WORDS(MW), .ADDR_BASE(AB), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst[1]), .exe_wb_en(exe_wb_en[1]), .exe_mem_r_en(exe_r[1]),
    .exe_mem_w_en(exe_w[1]), .exe_alu_res(exe_alu[1]), .exe_val_rm(exe_rm[1]),
    .exe_dest(exe_dst[1]), .stall(stall[1]), .wb_en(wb_en[1]), .mem_r_en(mem_r_en[1]),
    .dest(dest[1]), .alu_res(alu_res[1]), .mem_data(mem_data[1]), .mem_err(mem_err[1]),
    .state_dbg(state_dbg[1])
  );

  // model state and expectations
  op_t         m_r     [2];
  int          m_busy  [2];
  logic        m_took  [2];
  logic        e_valid [2] = '{1'b0, 1'b0};
  logic [31:0] m_mem   [2][MW];
  logic        e_stall [2];
  logic        e_wb    [2];
  logic        e_mr    [2];
  logic        e_err   [2];
  logic [31:0] e_alu   [2];
  logic [31:0] e_md    [2];
  logic [3:0]  e_dst   [2];

  int n_total = 0;
  int n_pass  = 0;
  int stall_seen;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d): got 0x%08h, expected 0x%08h", name, d, act, exp);
  endtask

  // One edge of the model: an op retires once its wait budget is spent, then the
  // next op is taken from the inputs and given a fresh budget.
  task automatic model_step(input int d);
    op_t    cur;
    longint a64, off;
    int     idx;
    m_took[d] = 1'b0;
    if (rst[d]) begin
      m_r[d] = '0; m_busy[d] = 0; e_valid[d] = 1'b1;
      e_wb[d] = 0; e_mr[d] = 0; e_err[d] = 0; e_alu[d] = 0; e_md[d] = 0; e_dst[d] = 0;
    end else if (m_busy[d] > 0) begin
      m_busy[d]--;
      e_wb[d] = 0; e_mr[d] = 0; e_err[d] = 0;
    end else begin
      cur = m_r[d];
      e_wb[d] = cur.wb; e_mr[d] = cur.r; e_alu[d] = cur.a; e_dst[d] = cur.ds;
      e_md[d] = 0; e_err[d] = 0;
      if (cur.r || cur.w) begin
        a64 = 0;
        a64[31:0] = cur.a;
        off = a64 - AB;
        if (off >= 0 && off < MW * 4) begin
          idx = int'(off / 4);
          if (cur.r) e_md[d] = m_mem[d][idx];
          if (cur.w) m_mem[d][idx] = cur.v;
        end else begin
          e_err[d] = 1;
        end
      end
      m_r[d] = {exe_wb_en[d], exe_r[d], exe_w[d], exe_alu[d], exe_rm[d], exe_dst[d]};
      m_busy[d] = (exe_r[d] || exe_w[d]) ? wait_of(d) : 0;
      m_took[d] = 1'b1;
    end
    e_stall[d] = (m_busy[d] > 0);
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (e_valid[d]) begin
        chk(d, "stall",    32'(stall[d]),    32'(e_stall[d]));
        chk(d, "wb_en",    32'(wb_en[d]),    32'(e_wb[d]));
        chk(d, "mem_r_en", 32'(mem_r_en[d]), 32'(e_mr[d]));
        chk(d, "mem_err",  32'(mem_err[d]),  32'(e_err[d]));
        chk(d, "alu_res",  alu_res[d],       e_alu[d]);
        chk(d, "mem_data", mem_data[d],      e_md[d]);
        chk(d, "dest",     32'(dest[d]),     32'(e_dst[d]));
        chk(d, "dbg_wait", 32'(state_dbg[d] == 2'd1), 32'(e_stall[d]));
      end
    end
  end

  // driver tasks
  task automatic set_in(input int d, input logic wb, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds);
    exe_wb_en[d] = wb; exe_r[d] = r; exe_w[d] = w;
    exe_alu[d] = a; exe_rm[d] = v; exe_dst[d] = ds;
  endtask

  task automatic drive(input int d, input logic wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds);
    int n;
    set_in(d, wb, r, w, a, v, ds);
    stall_seen = 0;
    n = 0;
    do begin
      if (stall[d] === 1'b1) stall_seen++;
      @(posedge clk); #1;
      n++;
    end while (!m_took[d] && n < 16);
    if (!m_took[d]) begin
      n_total++;
      $display("FAIL accept_timeout (dut%0d): op not taken after %0d edges", d, n);
    end
  endtask

  task automatic bubble(input int d);
    drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic pulse_reset(input int d);
    rst[d] = 1'b1;
    set_in(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic rand_op(input int d);
    logic [31:0] a;
    logic        r, w;
    int          k;
    k = $urandom_range(0, 9);
    a = AB + 4 * $urandom_range(0, MW - 1) + $urandom_range(0, 3);
    r = 1'b0; w = 1'b0;
    case (k)
      0, 1, 2: a = $urandom;
      3, 4:    r = 1'b1;
      5, 6:    w = 1'b1;
      7:       begin r = 1'b1; w = 1'b1; end
      default: begin
        r = 1'($urandom_range(0, 1));
        w = ~r | 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       a = $urandom_range(0, AB - 1);
          1:       a = AB + MW * 4 + $urandom_range(0, 4095);
          default: a = 32'hFFFF_FFFC + $urandom_range(0, 3);
        endcase
      end
    endcase
    drive(d, 1'($urandom_range(0, 1)), r, w, a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      set_in(d, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_stall",    32'(stall[d]),    32'd0);
      chk(d, "rst_wb_en",    32'(wb_en[d]),    32'd0);
      chk(d, "rst_mem_r_en", 32'(mem_r_en[d]), 32'd0);
      chk(d, "rst_mem_err",  32'(mem_err[d]),  32'd0);
      chk(d, "rst_alu_res",  alu_res[d],       32'd0);
      chk(d, "rst_mem_data", mem_data[d],      32'd0);
      chk(d, "rst_dest",     32'(dest[d]),     32'd0);
      rst[d] = 1'b0;
      set_in(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end

    // give every word a known value
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MW; i++) drive(d, 1'b0, 1'b0, 1'b1, 32'(AB + 4 * i), 32'hA500_0000 | 32'(i), 4'd0);
      bubble(d);
    end

    // ALU op passes through in one edge
    drive(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 4'd3);
    chk(0, "alu_no_stall", 32'(stall[0]), 32'd0);
    bubble(0);
    chk(0, "alu_wb_en", 32'(wb_en[0]), 32'd1);
    chk(0, "alu_res",   alu_res[0],    32'd5);
    chk(0, "alu_dest",  32'(dest[0]),  32'd3);
    chk(0, "alu_mem_r", 32'(mem_r_en[0]), 32'd0);

    // store then load the same word
    drive(0, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
    chk(0, "str_stall_first", 32'(stall[0]), 32'd1);
    drive(0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7);
    chk(0, "str_stall_cycles", 32'(stall_seen), 32'd2);
    bubble(0);
    chk(0, "ldr_stall_cycles", 32'(stall_seen), 32'd2);
    chk(0, "ldr_data",  mem_data[0],      32'hDEAD_BEEF);
    chk(0, "ldr_mem_r", 32'(mem_r_en[0]), 32'd1);
    chk(0, "ldr_wb_en", 32'(wb_en[0]),    32'd1);
    chk(0, "ldr_dest",  32'(dest[0]),     32'd7);

    // read-before-write on a combined op
    drive(0, 1'b1, 1'b1, 1'b1, 32'd1040, 32'h0000_0077, 4'd6);
    bubble(0);
    chk(0, "rbw_old", mem_data[0], 32'hA500_0004);
    drive(0, 1'b1, 1'b1, 1'b0, 32'd1041, 32'd0, 4'd6);
    bubble(0);
    chk(0, "rbw_new", mem_data[0], 32'h0000_0077);

    // out-of-range load below the base
    drive(0, 1'b1, 1'b1, 1'b0, 32'd1000, 32'd0, 4'd2);
    bubble(0);
    chk(0, "oor_ld_data", mem_data[0],     32'd0);
    chk(0, "oor_ld_err",  32'(mem_err[0]), 32'd1);
    @(posedge clk); #1;
    chk(0, "oor_ld_err_pulse", 32'(mem_err[0]), 32'd0);

    // out-of-range store one word past the end must not alias word 0
    drive(0, 1'b0, 1'b0, 1'b1, 32'(AB + 256), 32'h1234_5678, 4'd0);
    bubble(0);
    chk(0, "oor_st_err", 32'(mem_err[0]), 32'd1);
    drive(0, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    bubble(0);
    chk(0, "oor_st_word0", mem_data[0], 32'hA500_0000);

    // reset in the first stall cycle aborts the store
    drive(0, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0000_00AA, 4'd0);
    bubble(0);
    drive(0, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0000_0001, 4'd0);
    chk(0, "abort_stall_before", 32'(stall[0]), 32'd1);
    pulse_reset(0);
    chk(0, "abort_stall_after", 32'(stall[0]), 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd4);
    bubble(0);
    chk(0, "abort_kept", mem_data[0], 32'h0000_00AA);

    // zero-wait instance: back-to-back store then load
    drive(1, 1'b0, 1'b0, 1'b1, 32'd1040, 32'h0000_0055, 4'd0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd9);
    chk(1, "w0_no_stall_cnt", 32'(stall_seen), 32'd0);
    bubble(1);
    chk(1, "w0_ldr_data",  mem_data[1],      32'h0000_0055);
    chk(1, "w0_ldr_mem_r", 32'(mem_r_en[1]), 32'd1);
    chk(1, "w0_stall",     32'(stall[1]),    32'd0);

    // randomized traffic with occasional resets
    for (int d = 0; d < 2; d++) begin
      repeat (150) begin
        rand_op(d);
        if ($urandom_range(0, 29) == 0) pulse_reset(d);
      end
      bubble(d);
      bubble(d);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
